// File: rtl/vrf_banked_rd_seq.sv
// Banked vector register file with a sequenced multi-operand fetch into flop buffers.
// One bank per lane, one element per bank per register; v0 doubles as the mask register.
module vrf_banked_rd_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 32,
    parameter int LANES      = 4,
    parameter int NUM_RD_OPS = 3,
    parameter int ADDR_B     = $clog2(REG_NUM),
    parameter int ELEM_B     = $clog2(LANES),
    parameter int CNT_B      = $clog2(NUM_RD_OPS + 1)
) (
    input  logic                         clk_i,
    input  logic                         resetn_i,
    input  logic                         rd_req_i,
    output logic                         rd_ready_o,
    input  logic [CNT_B-1:0]             rd_op_cnt_i,
    input  logic                         rd_mask_en_i,
    input  logic [NUM_RD_OPS*ADDR_B-1:0] rd_addr_i,
    output logic                         rd_valid_o,
    input  logic [ELEM_B-1:0]            rd_elem_i,
    output logic [NUM_RD_OPS*DATA_WIDTH-1:0] op_rdata_o,
    output logic [DATA_WIDTH-1:0]        mask_rdata_o,
    input  logic                         wr_valid_i,
    output logic                         wr_ready_o,
    input  logic [ADDR_B-1:0]            wr_addr_i,
    input  logic [ELEM_B-1:0]            wr_elem_i,
    input  logic [DATA_WIDTH/8-1:0]      wr_be_i,
    input  logic [DATA_WIDTH-1:0]        wr_data_i,
    output logic [1:0]                   dbg_state_o
);

    // Handshakes: a fetch starts when rd_req_i & rd_ready_o at a clock edge; a write
    // commits when wr_valid_i & wr_ready_o at a clock edge; rd_valid_o is a 1-cycle pulse.

    localparam int IDX_B = CNT_B + 1;
    localparam int BE_W  = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    typedef logic [NUM_RD_OPS-1:0][ADDR_B-1:0] addr_vec_t;
    typedef logic [LANES-1:0][DATA_WIDTH-1:0]  row_t;

    state_e                      state_q, state_d;
    logic [IDX_B-1:0]            idx_q, idx_d;
    logic [IDX_B-1:0]            grp_n_q, grp_n_d;
    logic [CNT_B-1:0]            op_cnt_q, op_cnt_d;
    logic                        mask_en_q, mask_en_d;
    addr_vec_t                   addr_q, addr_d;
    logic [NUM_RD_OPS-1:0][LANES-1:0][DATA_WIDTH-1:0] op_buf_q, op_buf_d;
    row_t                        mask_buf_q, mask_buf_d;

    addr_vec_t                   req_addr;
    logic [CNT_B-1:0]            req_cnt;
    logic [IDX_B-1:0]            req_n;
    row_t                        ram_q;
    logic                        ram_rd_en;
    logic [ADDR_B-1:0]           ram_rd_addr;
    logic                        wr_fire;

    assign req_addr = rd_addr_i;
    assign req_cnt  = (int'(rd_op_cnt_i) > NUM_RD_OPS) ? CNT_B'(NUM_RD_OPS) : rd_op_cnt_i;
    assign req_n    = IDX_B'(req_cnt) + IDX_B'(rd_mask_en_i);
    assign wr_fire  = wr_valid_i & wr_ready_o;

    // Slots below the operand count map to operand addresses; the slot after them is v0.
    function automatic logic [ADDR_B-1:0] slot_addr(input int slot, input logic [CNT_B-1:0] cnt,
                                                    input addr_vec_t addrs);
        slot_addr = '0;
        for (int k = 0; k < NUM_RD_OPS; k++) begin
            if (k == slot && k < int'(cnt)) slot_addr = addrs[k];
        end
    endfunction

    function automatic logic grp_hit(input logic [ADDR_B-1:0] a, input logic [CNT_B-1:0] cnt,
                                     input logic mask_en, input addr_vec_t addrs);
        grp_hit = mask_en && (a == '0);
        for (int k = 0; k < NUM_RD_OPS; k++) begin
            if (k < int'(cnt) && addrs[k] == a) grp_hit = 1'b1;
        end
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        grp_n_d     = grp_n_q;
        op_cnt_d    = op_cnt_q;
        mask_en_d   = mask_en_q;
        addr_d      = addr_q;
        op_buf_d    = op_buf_q;
        mask_buf_d  = mask_buf_q;
        ram_rd_en   = 1'b0;
        ram_rd_addr = '0;
        rd_ready_o  = 1'b0;
        rd_valid_o  = 1'b0;
        wr_ready_o  = 1'b1;
        case (state_q)
            S_IDLE: begin
                rd_ready_o = 1'b1;
                if (rd_req_i) begin
                    op_cnt_d   = req_cnt;
                    mask_en_d  = rd_mask_en_i;
                    addr_d     = req_addr;
                    grp_n_d    = req_n;
                    wr_ready_o = !grp_hit(wr_addr_i, req_cnt, rd_mask_en_i, req_addr);
                    if (req_n == '0) begin
                        state_d = S_DONE;
                    end else begin
                        ram_rd_en   = 1'b1;
                        ram_rd_addr = slot_addr(0, req_cnt, req_addr);
                        idx_d       = IDX_B'(1);
                        state_d     = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                wr_ready_o = !grp_hit(wr_addr_i, op_cnt_q, mask_en_q, addr_q);
                // RAM output now holds the slot issued last cycle, i.e. slot idx-1.
                for (int k = 0; k < NUM_RD_OPS; k++) begin
                    if (int'(idx_q) - 1 == k && k < int'(op_cnt_q)) op_buf_d[k] = ram_q;
                end
                if (mask_en_q && int'(idx_q) - 1 == int'(op_cnt_q)) mask_buf_d = ram_q;
                if (idx_q < grp_n_q) begin
                    ram_rd_en   = 1'b1;
                    ram_rd_addr = slot_addr(int'(idx_q), op_cnt_q, addr_q);
                    idx_d       = idx_q + IDX_B'(1);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                rd_valid_o = 1'b1;
                idx_d      = '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            grp_n_q    <= '0;
            op_cnt_q   <= '0;
            mask_en_q  <= 1'b0;
            addr_q     <= '0;
            op_buf_q   <= '0;
            mask_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            grp_n_q    <= grp_n_d;
            op_cnt_q   <= op_cnt_d;
            mask_en_q  <= mask_en_d;
            addr_q     <= addr_d;
            op_buf_q   <= op_buf_d;
            mask_buf_q <= mask_buf_d;
        end
    end

    // Read-first banks: the registered read sees the row contents from before a same-edge write.
    for (genvar l = 0; l < LANES; l++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [REG_NUM];
        logic [DATA_WIDTH-1:0] bank_rdata;

        always_ff @(posedge clk_i) begin
            if (wr_fire && int'(wr_elem_i) == l) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (wr_be_i[b]) mem[wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
                end
            end
            if (ram_rd_en) bank_rdata <= mem[ram_rd_addr];
        end

        assign ram_q[l] = bank_rdata;
    end

    always_comb begin
        op_rdata_o = '0;
        for (int k = 0; k < NUM_RD_OPS; k++) begin
            op_rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = op_buf_q[k][rd_elem_i];
        end
        mask_rdata_o = mask_buf_q[rd_elem_i];
    end

    assign dbg_state_o = state_q;

endmodule
